// File: rtl/beep_sequencer.sv
// Turns one-cycle chime/alarm event pulses into timed on/off beep trains
// for the buzzer controller. Fully synchronous to clk, synchronous active-low reset.
//
// state | meaning
// IDLE  | no sequence, prescaler parked
// ON    | beep high for ON_MS
// OFF   | low between beeps of a train/group for OFF_MS
// GAP   | low between alarm groups for GAP_MS
module beep_sequencer #(
  parameter int TICK_DIV        = 50000,
  parameter int ON_MS           = 100,
  parameter int OFF_MS          = 100,
  parameter int GAP_MS          = 500,
  parameter int BEEPS_PER_GROUP = 4,
  parameter int ALARM_GROUPS    = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       chime_trig,
  input  logic [4:0] hour,
  input  logic       alarm_trig,
  input  logic       stop,
  output logic       beep,
  output logic       busy,
  output logic       alarm_active,
  output logic       done
);

  localparam int MS_MAX   = (ON_MS > OFF_MS) ? ((ON_MS > GAP_MS) ? ON_MS : GAP_MS)
                                             : ((OFF_MS > GAP_MS) ? OFF_MS : GAP_MS);
  localparam int BEEP_MAX = (BEEPS_PER_GROUP > 12) ? BEEPS_PER_GROUP : 12;
  localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MS_W     = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;
  localparam int BEEP_W   = (BEEP_MAX > 1) ? $clog2(BEEP_MAX) : 1;
  localparam int GRP_W    = (ALARM_GROUPS > 1) ? $clog2(ALARM_GROUPS) : 1;

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  state_t              state;
  logic [PRESC_W-1:0]  presc;
  logic [MS_W-1:0]     ms_left;
  logic [BEEP_W-1:0]   beeps_left;
  logic [GRP_W-1:0]    groups_left;

  logic              tick;
  logic              hour_valid;
  logic [4:0]        h12;
  logic [BEEP_W-1:0] chime_n_m1;

  always_comb begin
    tick       = (presc == PRESC_W'(TICK_DIV - 1));
    hour_valid = (hour <= 5'd23);
    h12        = (hour >= 5'd12) ? (hour - 5'd12) : hour;
    chime_n_m1 = (h12 == 5'd0) ? BEEP_W'(11) : BEEP_W'(h12 - 5'd1);
  end

  // Phase timers are down-counters of remaining ms; a phase ends on the tick
  // that arrives while the counter is already at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      presc        <= '0;
      ms_left      <= '0;
      beeps_left   <= '0;
      groups_left  <= '0;
      beep         <= 1'b0;
      busy         <= 1'b0;
      alarm_active <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state        <= IDLE;
        presc        <= '0;
        ms_left      <= '0;
        beeps_left   <= '0;
        groups_left  <= '0;
        beep         <= 1'b0;
        busy         <= 1'b0;
        alarm_active <= 1'b0;
      end else if (alarm_trig) begin
        state        <= ON;
        presc        <= '0;
        ms_left      <= MS_W'(ON_MS - 1);
        beeps_left   <= BEEP_W'(BEEPS_PER_GROUP - 1);
        groups_left  <= GRP_W'(ALARM_GROUPS - 1);
        beep         <= 1'b1;
        busy         <= 1'b1;
        alarm_active <= 1'b1;
      end else if (chime_trig && state == IDLE && hour_valid) begin
        state        <= ON;
        presc        <= '0;
        ms_left      <= MS_W'(ON_MS - 1);
        beeps_left   <= chime_n_m1;
        groups_left  <= '0;
        beep         <= 1'b1;
        busy         <= 1'b1;
        alarm_active <= 1'b0;
      end else if (state != IDLE) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) begin
          if (ms_left != '0) begin
            ms_left <= ms_left - 1'b1;
          end else begin
            case (state)
              ON: begin
                beep <= 1'b0;
                if (beeps_left != '0) begin
                  beeps_left <= beeps_left - 1'b1;
                  ms_left    <= MS_W'(OFF_MS - 1);
                  state      <= OFF;
                end else if (groups_left != '0) begin
                  groups_left <= groups_left - 1'b1;
                  beeps_left  <= BEEP_W'(BEEPS_PER_GROUP - 1);
                  ms_left     <= MS_W'(GAP_MS - 1);
                  state       <= GAP;
                end else begin
                  state        <= IDLE;
                  busy         <= 1'b0;
                  alarm_active <= 1'b0;
                  done         <= 1'b1;
                end
              end
              OFF, GAP: begin
                state   <= ON;
                beep    <= 1'b1;
                ms_left <= MS_W'(ON_MS - 1);
              end
              default: state <= IDLE;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_beep_sequencer.sv
// Scoreboard bench for beep_sequencer: the driver queues the expected per-cycle
// output waveform built from whole-phase durations; a monitor pops and compares.
module tb_beep_sequencer;
  localparam int TICK_DIV = 5, ON_MS = 2, OFF_MS = 1, GAP_MS = 3, BPG = 2, GROUPS = 2;
  localparam int ON_C = ON_MS * TICK_DIV, OFF_C = OFF_MS * TICK_DIV, GAP_C = GAP_MS * TICK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       chime_trig = 1'b0;
  logic [4:0] hour = 5'd0;
  logic       alarm_trig = 1'b0;
  logic       stop = 1'b0;
  logic       beep, busy, alarm_active, done;

  beep_sequencer #(
    .TICK_DIV(TICK_DIV), .ON_MS(ON_MS), .OFF_MS(OFF_MS), .GAP_MS(GAP_MS),
    .BEEPS_PER_GROUP(BPG), .ALARM_GROUPS(GROUPS)
  ) dut (
    .clk(clk), .rst(rst), .chime_trig(chime_trig), .hour(hour),
    .alarm_trig(alarm_trig), .stop(stop), .beep(beep), .busy(busy),
    .alarm_active(alarm_active), .done(done)
  );

  always #5 clk = ~clk;

  // expected entry: {beep, busy, alarm_active, done}
  logic [3:0] q[$];
  logic       last_busy = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         n_rise = 0;

  task automatic push_n(input logic [3:0] v, input int n);
    repeat (n) q.push_back(v);
  endtask

  task automatic load_chime(input int hr);
    int n;
    n = hr % 12;
    if (n == 0) n = 12;
    q.delete();
    for (int i = 0; i < n; i++) begin
      push_n(4'b1100, ON_C);
      if (i < n - 1) push_n(4'b0100, OFF_C);
    end
    q.push_back(4'b0001);
  endtask

  task automatic load_alarm();
    q.delete();
    for (int g = 0; g < GROUPS; g++) begin
      for (int b = 0; b < BPG; b++) begin
        push_n(4'b1110, ON_C);
        if (b < BPG - 1) push_n(4'b0110, OFF_C);
      end
      if (g < GROUPS - 1) push_n(4'b0110, GAP_C);
    end
    q.push_back(4'b0001);
  endtask

  // Apply inputs for one clock edge and update the reference model.
  task automatic cycle(input logic r, input logic c, input int h, input logic a, input logic s);
    rst = r; chime_trig = c; hour = 5'(h); alarm_trig = a; stop = s;
    if (!r || s) q.delete();
    else if (a) load_alarm();
    else if (c && !last_busy && h <= 23) load_chime(h);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    logic [3:0] exp_v, got_v, prev_v;
    prev_v = 4'b0000;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      exp_v = (q.size() > 0) ? q.pop_front() : 4'b0000;
      last_busy = exp_v[2];
      got_v = {beep, busy, alarm_active, done};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL outputs cycle %0d: got beep/busy/alarm/done=%b expected %b", cyc, got_v, exp_v);
      end
      if (got_v[3] && !prev_v[3]) n_rise++;
      prev_v = got_v;
    end
  end

  initial begin : driver
    int rise0;
    // reset held with a chime request present
    repeat (3) cycle(1'b0, 1'b1, 3, 1'b0, 1'b0);
    idle(3);
    // chime 14h -> 2 beeps, with a rising-edge count cross-check
    rise0 = n_rise;
    cycle(1'b1, 1'b1, 14, 1'b0, 1'b0);
    idle(40);
    n_cmp++;
    if (n_rise - rise0 != 2) begin
      n_bad++;
      $display("FAIL chime14_rises: got %0d expected 2", n_rise - rise0);
    end
    // chime 0h, 12h -> 12 beeps; 24h ignored
    rise0 = n_rise;
    cycle(1'b1, 1'b1, 0, 1'b0, 1'b0);
    idle(190);
    cycle(1'b1, 1'b1, 12, 1'b0, 1'b0);
    idle(190);
    n_cmp++;
    if (n_rise - rise0 != 24) begin
      n_bad++;
      $display("FAIL chime0_12_rises: got %0d expected 24", n_rise - rise0);
    end
    cycle(1'b1, 1'b1, 24, 1'b0, 1'b0);
    idle(20);
    // alarm full pattern
    rise0 = n_rise;
    cycle(1'b1, 1'b0, 0, 1'b1, 1'b0);
    idle(80);
    n_cmp++;
    if (n_rise - rise0 != 4) begin
      n_bad++;
      $display("FAIL alarm_rises: got %0d expected 4", n_rise - rise0);
    end
    // alarm preempts a chime inside its first OFF
    cycle(1'b1, 1'b1, 5, 1'b0, 1'b0);
    idle(11);
    cycle(1'b1, 1'b0, 0, 1'b1, 1'b0);
    idle(100);
    // stop mid-ON, then stop together with alarm_trig
    cycle(1'b1, 1'b0, 0, 1'b1, 1'b0);
    idle(4);
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b1);
    idle(10);
    cycle(1'b1, 1'b0, 0, 1'b1, 1'b1);
    idle(10);
    // collisions: simultaneous triggers, chime during alarm, alarm restart
    cycle(1'b1, 1'b1, 7, 1'b1, 1'b0);
    idle(20);
    cycle(1'b1, 1'b1, 7, 1'b0, 1'b0);
    idle(7);
    cycle(1'b1, 1'b0, 0, 1'b1, 1'b0);
    idle(80);
    // randomized traffic
    for (int i = 0; i < 5000; i++) begin
      logic r, c, a, s;
      r = ($urandom_range(0, 999) >= 3);
      c = ($urandom_range(0, 99) < 3);
      a = ($urandom_range(0, 999) < 6);
      s = ($urandom_range(0, 999) < 5);
      cycle(r, c, int'($urandom_range(0, 31)), a, s);
    end
    idle(200);
    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
